// File: rtl/scoreboard_hazard_unit.sv
// Hazard unit for the 5-stage core: forwarding, load-use, cache-miss and branch-flush control,
// plus a per-register latency scoreboard that stalls decode on hazards against multi-cycle ops.
module scoreboard_hazard_unit #(
   parameter int unsigned REG_AW         = 5,
   parameter int unsigned LAT_W          = 4,
   parameter int unsigned ZERO_HARDWIRED = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rs3_d,
   input  logic [REG_AW-1:0] rd_d,
   input  logic              rs1_used_d,
   input  logic              rs2_used_d,
   input  logic              rs3_used_d,
   input  logic              rd_used_d,
   input  logic [REG_AW-1:0] rs1_e,
   input  logic [REG_AW-1:0] rs2_e,
   input  logic [REG_AW-1:0] rs3_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic              pc_src_e,
   input  logic              result_src_e_0,
   input  logic              issue_mc_e,
   input  logic [LAT_W-1:0]  lat_e,
   input  logic [REG_AW-1:0] rd_m,
   input  logic              reg_write_m,
   input  logic              result_src_m_0,
   input  logic              cache_data_valid,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              reg_write_w,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              stall_m,
   output logic              stall_w,
   output logic              flush_d,
   output logic              flush_e,
   output logic [1:0]        forward_a_e,
   output logic [1:0]        forward_b_e,
   output logic [1:0]        forward_c_e,
   output logic              sb_busy_any
);

   localparam int unsigned NREG = 2 ** REG_AW;

   logic [NREG-1:0]             busy_q, busy_d;
   logic [NREG-1:0][LAT_W-1:0]  cnt_q, cnt_d;
   logic                        cache_stall, lw_stall, sb_stall, issue_accept;

   // Register 0 is inert in the integer file.
   function automatic logic live(input logic [REG_AW-1:0] r);
      return (ZERO_HARDWIRED == 0) || (r != '0);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                          input logic [REG_AW-1:0] rdm, input logic wm,
                                          input logic [REG_AW-1:0] rdw, input logic ww);
      if (!live(rs))            return 2'b00;
      if (wm && (rs == rdm))    return 2'b10;
      if (ww && (rs == rdw))    return 2'b01;
      return 2'b00;
   endfunction

   always_comb begin
      cache_stall = result_src_m_0 & ~cache_data_valid;
      lw_stall    = result_src_e_0 & live(rd_e) &
                    ((rs1_used_d & (rs1_d == rd_e)) |
                     (rs2_used_d & (rs2_d == rd_e)) |
                     (rs3_used_d & (rs3_d == rd_e)));
      sb_stall    = (rs1_used_d & live(rs1_d) & busy_q[rs1_d]) |
                    (rs2_used_d & live(rs2_d) & busy_q[rs2_d]) |
                    (rs3_used_d & live(rs3_d) & busy_q[rs3_d]) |
                    (rd_used_d  & live(rd_d)  & busy_q[rd_d]);
      issue_accept = issue_mc_e & ~cache_stall & live(rd_e);
   end

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (!cache_stall) begin
         for (int i = 0; i < NREG; i++) begin
            if (busy_q[i]) begin
               if (cnt_q[i] == LAT_W'(1)) begin
                  busy_d[i] = 1'b0;
                  cnt_d[i]  = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] - LAT_W'(1);
               end
            end
         end
      end
      // Applied after the countdown so a same-edge reissue overrides the clear.
      if (issue_accept) begin
         busy_d[rd_e] = 1'b1;
         cnt_d[rd_e]  = (lat_e == '0) ? LAT_W'(1) : lat_e;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      stall_f     = rst | lw_stall | sb_stall | cache_stall;
      stall_d     = stall_f;
      stall_e     = cache_stall & ~rst;
      stall_m     = stall_e;
      stall_w     = stall_e;
      flush_d     = rst | pc_src_e;
      // E holds during a cache stall so the hazard is re-evaluated afterwards.
      flush_e     = rst | ((lw_stall | sb_stall | pc_src_e) & ~cache_stall);
      forward_a_e = rst ? 2'b00 : fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
      forward_b_e = rst ? 2'b00 : fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
      forward_c_e = rst ? 2'b00 : fwd_sel(rs3_e, rd_m, reg_write_m, rd_w, reg_write_w);
      sb_busy_any = |busy_q;
   end

endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
- Parametrised hazard unit for the in-order 5-stage core (F/D/E/M/W) that adds multi-cycle execution units (FPU, divider) to the existing forwarding, load-use, cache-miss and branch-flush handling.
- A per-register scoreboard with latency countdowns stalls decode on RAW and WAW hazards against in-flight multi-cycle ops.
- One instance serves one register class; the core instantiates one for the integer file and one for the FP file.

Parameters:
- REG_AW, 5, register address width; the scoreboard holds 2**REG_AW entries.
- LAT_W, 4, latency counter width; maximum multi-cycle latency is 2**LAT_W-1.
- ZERO_HARDWIRED, 1, 1 means register 0 never hazards, forwards or goes busy (integer file); 0 means register 0 is ordinary (FP file).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- rs1_d, rs2_d, rs3_d, rd_d  in  REG_AW each  decode-stage sources and destination.
- rs1_used_d, rs2_used_d, rs3_used_d, rd_used_d  in  1 each  operand/destination valid qualifiers.
- rs1_e, rs2_e, rs3_e, rd_e  in  REG_AW each  exec-stage sources and destination.
- pc_src_e  in  1  branch/jump taken in E.
- result_src_e_0  in  1  load in E.
- issue_mc_e  in  1  E holds a multi-cycle op writing rd_e.
- lat_e  in  LAT_W  cycles until that result can be forwarded from W.
- rd_m  in  REG_AW, reg_write_m  in  1, result_src_m_0  in  1  memory-stage destination, write enable, load flag.
- cache_data_valid  in  1  data cache has returned load data.
- rd_w  in  REG_AW, reg_write_w  in  1  writeback-stage destination and write enable.
- stall_f, stall_d, stall_e, stall_m, stall_w  out  1 each  pipeline register holds.
- flush_d, flush_e  out  1 each  pipeline register flushes.
- forward_a_e, forward_b_e, forward_c_e  out  2 each  operand mux selects: 00 register file, 01 W, 10 M.
- sb_busy_any  out  1  any scoreboard entry busy (drain/fence).

Behaviour:
- Gating with ZERO_HARDWIRED=1: a register-0 operand or destination never matches, stalls, forwards or sets busy.
- Forwarding (combinational, per operand x in {a,b,c} with sources rs1_e/rs2_e/rs3_e):
  - 10 if rsx_e==rd_m & reg_write_m.
  - Otherwise 01 if rsx_e==rd_w & reg_write_w.
  - Otherwise 00. M has priority over W.
- lw_stall = result_src_e_0 & rd_e matches any used rs of D.
- cache_stall = result_src_m_0 & ~cache_data_valid.
- Scoreboard, per entry: busy bit plus LAT_W-bit count.
  - sb_stall = any used rs of D is busy, or (rd_used_d & rd_d busy) for WAW.
  - Issue accept = issue_mc_e & ~cache_stall. It sets busy[rd_e]=1 and count=max(lat_e,1) at the clock edge.
  - Each cycle with ~cache_stall, every busy entry decrements. An entry whose count is 1 clears busy on that edge.
  - While cache_stall=1, all counts and busy bits freeze.
  - Same-cycle issue and clear of the same entry: the issue wins (busy stays 1, count reloads).
  - The issuing instruction is not flushed by a taken branch in the same E stage. Only younger D/F are flushed, so the issue stands.
- Outputs:
  - stall_f = stall_d = lw_stall | sb_stall | cache_stall.
  - stall_e = stall_m = stall_w = cache_stall.
  - flush_d = pc_src_e.
  - flush_e = (lw_stall | sb_stall | pc_src_e) & ~cache_stall. E keeps its contents while cache-stalled so the hazard is re-evaluated.
- sb_busy_any = OR of all busy bits, registered value.
- Reset (synchronous, active-high):
  - All busy bits and counts cleared on the edge.
  - While rst=1: stall_f=stall_d=1, flush_d=flush_e=1, stall_e/m/w=0, forwards=00.
  - Reset mid-countdown discards all in-flight entries.
  - First cycle after reset: sb_busy_any=0.

Test Plan:
- Forward priority: rd_m=rd_w=rs1_e=5, reg_write_m=reg_write_w=1 -> forward_a_e=10. Clear reg_write_m -> 01. With rs1_e=0 and ZERO_HARDWIRED=1 -> 00.
- Load-use: result_src_e_0=1, rd_e=7, rs2_d=7 used -> stall_f=stall_d=flush_e=1 for one cycle. With rs2_used_d=0 -> no stall.
- Multi-cycle RAW: issue rd_e=3, lat_e=4, then hold rs1_d=3 used -> stall_d=1 for exactly 4 cycles, released on the 5th. sb_busy_any falls the same cycle.
- Freeze: as above, with cache_stall=1 for 3 cycles mid-count -> stall_d lasts 7 cycles. flush_e=0 during cache_stall. stall_e/m/w=1 only during cache_stall.
- WAW and reload: issue rd=9 lat=6; 2 cycles later rd_d=9 used -> stall. Re-issue rd=9 lat=2 on the clear cycle -> busy stays 1 for 2 more cycles. lat_e=0 -> busy for 1 cycle.
- Reset: assert rst with 3 entries busy -> stall_f=flush_e=1 while rst=1. After deassert, sb_busy_any=0 and no sb_stall. ZERO_HARDWIRED=0: issue rd_e=0 lat=2 -> rs1_d=0 stalls 2 cycles.
